// File: rtl/mini_processor_top.sv
// ---------------------------------------------------------------------------
// mini_processor_top
//
// Memory-mapped multiply engine on a single-master bus. The master loads two
// ten-entry operand arrays (A, B), then writes a control word to start the
// engine. The engine forms the ten unsigned 32x32 products one after another
// with a shift-add multiplier and stores them as 64-bit results (R). It then
// parks in DONE and, if enabled, raises a level interrupt.
//
// Ports:
//   clk           rising-edge system clock
//   reset_n       asynchronous, active-low reset
//   m_req         master bus request
//   m_wr          1 = write, 0 = read
//   m_addr[15:0]  word address
//   m_dout[31:0]  write data from master
//   m_grant       bus grant (m_req qualified by reset)
//   m_din[63:0]   read data to master (0 when no valid read)
//   interrupt_out completion interrupt, level
//   state[2:0]    engine state: IDLE=0 LOAD=1 MUL=2 STORE=3 DONE=4
//
// Address map (i = 0..9):
//   0x0100+i  write A[i], read R[i]
//   0x0110+i  write B[i], read {32'h0, B[i]}
//   0x1111    write control {irq_en, start}, read {irq_en, interrupt_out, state}
// ---------------------------------------------------------------------------
module mini_processor_top (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m_req,
    input  logic        m_wr,
    input  logic [15:0] m_addr,
    input  logic [31:0] m_dout,
    output logic        m_grant,
    output logic [63:0] m_din,
    output logic        interrupt_out,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL   = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0] a_mem [10];
    logic [31:0] b_mem [10];
    logic [63:0] r_mem [10];

    logic [3:0]  idx;
    logic [4:0]  count;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic        irq_en;
    logic        irq_q;

    logic bus_valid;
    logic bus_wr;
    logic bus_rd;
    logic a_hit;
    logic b_hit;
    logic ctrl_hit;
    logic busy;
    logic ctrl_wr;
    logic start_go;
    logic stop_go;

    // Only one master exists, so the grant simply follows the request
    // outside reset.
    assign m_grant   = m_req & reset_n;
    assign bus_valid = m_req & m_grant;
    assign bus_wr    = bus_valid & m_wr;
    assign bus_rd    = bus_valid & ~m_wr;

    // Both array windows are 16 words wide but only the first ten hit;
    // the gap decodes like any other unmapped address.
    assign a_hit    = (m_addr[15:4] == 12'h010) && (m_addr[3:0] < 4'd10);
    assign b_hit    = (m_addr[15:4] == 12'h011) && (m_addr[3:0] < 4'd10);
    assign ctrl_hit = (m_addr == 16'h1111);

    assign busy     = (state_q == S_LOAD) || (state_q == S_MUL) || (state_q == S_STORE);
    assign ctrl_wr  = bus_wr & ctrl_hit;
    assign start_go = ctrl_wr & m_dout[0] & ((state_q == S_IDLE) || (state_q == S_DONE));
    assign stop_go  = ctrl_wr & ~m_dout[0] & (state_q == S_DONE);

    // Engine state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. MUL runs until the 32nd iteration (count 31), and
    // the last STORE (index 9) ends the run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go) state_d = S_LOAD;
            S_LOAD:  state_d = S_MUL;
            S_MUL:   if (count == 5'd31) state_d = S_STORE;
            S_STORE: state_d = (idx == 4'd9) ? S_DONE : S_LOAD;
            S_DONE: begin
                if (start_go) begin
                    state_d = S_LOAD;
                end else if (stop_go) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand arrays. Writes are dropped while the engine is reading them
    // so a run always sees a stable operand set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 10; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (bus_wr && !busy) begin
            if (a_hit) begin
                a_mem[m_addr[3:0]] <= m_dout;
            end
            if (b_hit) begin
                b_mem[m_addr[3:0]] <= m_dout;
            end
        end
    end

    // Datapath: shift-add multiplier, result store, interrupt.
    // Each MUL cycle consumes the multiplier LSB and doubles the
    // multiplicand, so after 32 cycles acc holds the full 64-bit product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx    <= '0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_go) begin
                        irq_en <= m_dout[1];
                        idx    <= '0;
                        irq_q  <= 1'b0;
                        for (int i = 0; i < 10; i++) begin
                            r_mem[i] <= '0;
                        end
                    end else if (stop_go) begin
                        irq_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    mcand  <= {32'h0, a_mem[idx]};
                    mplier <= b_mem[idx];
                    acc    <= '0;
                    count  <= '0;
                end
                S_MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                end
                S_STORE: begin
                    r_mem[idx] <= acc;
                    if (idx == 4'd9) begin
                        irq_q <= irq_en;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read mux straight from registered storage; a read that coincides with
    // a STORE edge therefore returns the pre-store value.
    always_comb begin
        m_din = '0;
        if (bus_rd) begin
            if (a_hit) begin
                m_din = r_mem[m_addr[3:0]];
            end else if (b_hit) begin
                m_din = {32'h0, b_mem[m_addr[3:0]]};
            end else if (ctrl_hit) begin
                m_din = {59'h0, irq_en, irq_q, state_q};
            end
        end
    end

    assign interrupt_out = irq_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mini_processor_top.sv
// ---------------------------------------------------------------------------
// tb_mini_processor_top
//
// Drives the multiply processor over its bus and compares what comes back
// with a reference model: the operand arrays are kept as plain arrays, each
// result is the arithmetic product of its operands, and the expected engine
// state and result availability are derived from the run's cycle schedule
// (34 cycles per element, DONE after 340).
// ---------------------------------------------------------------------------
module tb_mini_processor_top;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    logic        m_grant;
    logic [63:0] m_din;
    logic        interrupt_out;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    logic [31:0] a_m [10];
    logic [31:0] b_m [10];
    logic        irq_m;

    mini_processor_top dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m_req         (m_req),
        .m_wr          (m_wr),
        .m_addr        (m_addr),
        .m_dout        (m_dout),
        .m_grant       (m_grant),
        .m_din         (m_din),
        .interrupt_out (interrupt_out),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] product(input int j);
        logic [63:0] x;
        logic [63:0] y;
        x = {32'h0, a_m[j]};
        y = {32'h0, b_m[j]};
        return x * y;
    endfunction

    // Engine state k cycles after the start edge.
    function automatic logic [2:0] state_at(input int k);
        int p;
        if (k >= 340) return 3'd4;
        p = k % 34;
        if (p == 0)  return 3'd1;
        if (p == 33) return 3'd3;
        return 3'd2;
    endfunction

    // Bus helpers; called at posedge+1, a write returns at the next posedge+1.
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = addr;
        m_dout = data;
        @(posedge clk);
        #1;
        m_req = 1'b0;
        m_wr  = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [63:0] data);
        m_req  = 1'b1;
        m_wr   = 1'b0;
        m_addr = addr;
        #1;
        data  = m_din;
        m_req = 1'b0;
    endtask

    task automatic load_operands();
        for (int i = 0; i < 10; i++) begin
            bus_write(16'h0100 + 16'(i), a_m[i]);
            bus_write(16'h0110 + 16'(i), b_m[i]);
        end
    endtask

    task automatic check_arrays(input string tag);
        logic [63:0] d;
        for (int j = 0; j < 10; j++) begin
            bus_read(16'h0100 + 16'(j), d);
            checkOutput($sformatf("%s_R%0d", tag, j), d, product(j));
            bus_read(16'h0110 + 16'(j), d);
            checkOutput($sformatf("%s_B%0d", tag, j), d, {32'h0, b_m[j]});
        end
    endtask

    // Starts a run with the given control word and follows it cycle by
    // cycle. poke = write operands/control during MUL (must be ignored);
    // abort_at >= 0 asserts reset at that cycle of the run.
    task automatic applyStimulus(input logic [31:0] ctrl, input int abort_at, input bit poke);
        logic [63:0] d;
        int          j;
        bit          aborted;
        aborted = 1'b0;
        bus_write(16'h1111, ctrl);
        irq_m = ctrl[1];
        for (int k = 0; k < 346 && !aborted; k++) begin
            if (k == abort_at) begin
                m_req   = 1'b1;
                m_wr    = 1'b0;
                m_addr  = 16'h1111;
                reset_n = 1'b0;
                #1;
                checkOutput("rst_state", state, 3'd0);
                checkOutput("rst_irq", interrupt_out, 1'b0);
                checkOutput("rst_din", m_din, 64'h0);
                checkOutput("rst_grant", m_grant, 1'b0);
                m_req   = 1'b0;
                reset_n = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    a_m[i] = '0;
                    b_m[i] = '0;
                end
                irq_m = 1'b0;
                @(posedge clk);
                #1;
                check_arrays("post_rst");
                bus_read(16'h1111, d);
                checkOutput("post_rst_ctrl", d, 64'h0);
                aborted = 1'b1;
            end else begin
                checkOutput($sformatf("state_k%0d", k), state, state_at(k));
                checkOutput($sformatf("irq_k%0d", k), interrupt_out, (k >= 340) && irq_m);
                j = $urandom_range(0, 9);
                bus_read(16'h0100 + 16'(j), d);
                checkOutput($sformatf("R%0d_k%0d", j, k), d, (k >= 34 * (j + 1)) ? product(j) : 64'h0);
                if (poke && k == 98) begin
                    m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h0103; m_dout = 32'h55;
                end else if (poke && k == 99) begin
                    m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h1111; m_dout = 32'h1;
                end else if (poke && k == 100) begin
                    m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h0114; m_dout = 32'hDEAD_BEEF;
                end
                @(posedge clk);
                #1;
                m_req = 1'b0;
                m_wr  = 1'b0;
            end
        end
        if (!aborted) begin
            check_arrays("done");
            bus_read(16'h1111, d);
            checkOutput("done_ctrl", d, {59'h0, irq_m, irq_m, 3'd4});
        end
    endtask

    initial begin
        logic [63:0] d;
        reset_n = 1'b0;
        m_req   = 1'b1;
        m_wr    = 1'b0;
        m_addr  = 16'h1111;
        m_dout  = '0;
        for (int i = 0; i < 10; i++) begin
            a_m[i] = '0;
            b_m[i] = '0;
        end
        irq_m = 1'b0;
        #13;
        checkOutput("reset_state", state, 3'd0);
        checkOutput("reset_din", m_din, 64'h0);
        checkOutput("reset_irq", interrupt_out, 1'b0);
        checkOutput("reset_grant", m_grant, 1'b0);
        reset_n = 1'b1;
        #1;
        checkOutput("release_grant", m_grant, 1'b1);
        m_req = 1'b0;
        @(posedge clk);
        #1;

        // Register readback and unmapped address.
        bus_write(16'h0115, 32'h1111_5516);
        b_m[5] = 32'h1111_5516;
        bus_read(16'h0115, d);
        checkOutput("rb_B5", d, 64'h0000_0000_1111_5516);
        bus_write(16'h0200, 32'hCAFE_F00D);
        bus_read(16'h0200, d);
        checkOutput("rb_unmapped", d, 64'h0);
        bus_read(16'h010A, d);
        checkOutput("rb_gap", d, 64'h0);

        // Directed full run with interrupt enabled.
        for (int i = 0; i < 10; i++) begin
            a_m[i] = 32'(i);
            b_m[i] = 32'h1111_1111 + 32'(i) * 32'h0000_0C01;
        end
        b_m[0] = 32'h1111_0011;
        b_m[1] = 32'h1111_1112;
        b_m[9] = 32'h1111_8920;
        load_operands();
        applyStimulus(32'h1111_1413, -1, 1'b0);
        bus_read(16'h0101, d);
        checkOutput("dir_R1", d, 64'h0000_0000_1111_1112);
        bus_read(16'h0109, d);
        checkOutput("dir_R9", d, 64'h0000_0000_999D_D220);

        // Clear from DONE.
        bus_write(16'h1111, 32'h0);
        checkOutput("clear_state", state, 3'd0);
        checkOutput("clear_irq", interrupt_out, 1'b0);

        // Max operands, interrupt disabled, busy-time writes ignored.
        for (int i = 0; i < 10; i++) begin
            a_m[i] = $urandom;
            b_m[i] = $urandom;
        end
        a_m[0] = 32'hFFFF_FFFF;
        b_m[0] = 32'hFFFF_FFFF;
        load_operands();
        applyStimulus(32'h1, -1, 1'b1);
        bus_read(16'h0100, d);
        checkOutput("max_R0", d, 64'hFFFF_FFFE_0000_0001);

        // Random runs restarted directly from DONE.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) begin
                a_m[i] = $urandom;
                b_m[i] = $urandom;
            end
            load_operands();
            applyStimulus({30'($urandom), 1'($urandom), 1'b1}, -1, 1'b0);
        end

        // Reset in the middle of a run.
        applyStimulus(32'h3, 50, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
